fetch_align_ctrl: RTL and testbench

Fetch-alignment controller that sequences the front-end byte rotator. It owns the 64-byte fetch line register, the per-16-byte region valid mask and the byte shift pointer, and it requests and accepts line refills. It emits one 32-bit instruction per ready/valid handshake to decode, and handles redirects and line-crossing.

---
 rtl/fetch_align_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fetch_align_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align_ctrl.sv
// Fetch-alignment controller: owns the fetch line, region valid mask and byte
// shift pointer feeding the rotator, requests line refills and issues instructions.
module fetch_align_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_redir_valid,
   input  logic [31:0]  i_redir_pc,
   output logic         o_req_valid,
   input  logic         i_req_ready,
   output logic [31:0]  o_req_addr,
   output logic         o_req_epoch,
   input  logic         i_fill_valid,
   input  logic         i_fill_epoch,
   input  logic [1:0]   i_fill_idx,
   input  logic [127:0] i_fill_data,
   output logic [511:0] o_rot_data_in,
   output logic [5:0]   o_rot_shift,
   output logic [3:0]   o_rot_ibuff_valid,
   input  logic [31:0]  i_rot_data_out,
   input  logic         i_rot_valid_out,
   output logic         o_instr_valid,
   input  logic         i_instr_ready,
   output logic [31:0]  o_instr,
   output logic [31:0]  o_instr_pc,
   output logic         o_misalign
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [25:0]   r_line_addr;
   logic [5:0]    r_shift;
   logic [3:0]    r_rvalid;
   logic          r_epoch;
   logic [511:0]  r_line;
   logic          r_misalign;

   logic          w_redir_misal;
   logic          w_line_end;
   logic          w_handshake;
   logic          w_fill_accept;
   logic          w_req_valid;
   logic          w_instr_valid;

   assign w_redir_misal = (i_redir_pc[1:0] != 2'b00);
   assign w_line_end    = (r_shift == 6'd60);
   assign w_handshake   = w_instr_valid & i_instr_ready;
   // Fills only land while running on the current epoch; a redirect in the same cycle wins.
   assign w_fill_accept = i_fill_valid & ~i_redir_valid & (r_state == S_RUN) &
                          (i_fill_epoch == r_epoch);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic; a redirect overrides every state.
   always_comb begin
      w_state_nxt = r_state;
      if (i_redir_valid) begin
         if (w_redir_misal) begin
            w_state_nxt = S_IDLE;
         end else begin
            w_state_nxt = S_REQ;
         end
      end else begin
         case (r_state)
            S_IDLE: w_state_nxt = S_IDLE;
            S_REQ: begin
               if (i_req_ready) begin
                  w_state_nxt = S_RUN;
               end else begin
                  w_state_nxt = S_REQ;
               end
            end
            S_RUN: begin
               if (w_handshake && w_line_end) begin
                  w_state_nxt = S_REQ;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // FSM outputs; instruction valid is masked by a redirect so no handshake can race it.
   always_comb begin
      w_req_valid   = 1'b0;
      w_instr_valid = 1'b0;
      case (r_state)
         S_REQ: begin
            w_req_valid   = 1'b1;
            w_instr_valid = 1'b0;
         end
         S_RUN: begin
            w_req_valid   = 1'b0;
            w_instr_valid = i_rot_valid_out & ~i_redir_valid;
         end
         default: begin
            w_req_valid   = 1'b0;
            w_instr_valid = 1'b0;
         end
      endcase
   end

   // Line address, shift pointer, region valid mask, epoch and misalign flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_line_addr <= 26'd0;
         r_shift     <= 6'd0;
         r_rvalid    <= 4'b0000;
         r_epoch     <= 1'b0;
         r_misalign  <= 1'b0;
      end else if (i_redir_valid) begin
         r_line_addr <= i_redir_pc[31:6];
         r_shift     <= i_redir_pc[5:0];
         r_rvalid    <= 4'b0000;
         r_epoch     <= ~r_epoch;
         r_misalign  <= w_redir_misal;
      end else begin
         if (w_handshake && w_line_end) begin
            r_shift     <= 6'd0;
            r_line_addr <= r_line_addr + 26'd1;
         end else if (w_handshake) begin
            r_shift     <= r_shift + 6'd4;
         end else begin
            r_shift     <= r_shift;
         end
         // Moving to a new line invalidates everything, including a fill for the old line.
         if (w_handshake && w_line_end) begin
            r_rvalid <= 4'b0000;
         end else if (w_fill_accept) begin
            r_rvalid[i_fill_idx] <= 1'b1;
         end else begin
            r_rvalid <= r_rvalid;
         end
      end
   end

   // Fetch line storage; region 0 holds the lowest-addressed bytes in the top bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_line <= 512'd0;
      end else if (w_fill_accept) begin
         case (i_fill_idx)
            2'd0:    r_line[511:384] <= i_fill_data;
            2'd1:    r_line[383:256] <= i_fill_data;
            2'd2:    r_line[255:128] <= i_fill_data;
            2'd3:    r_line[127:0]   <= i_fill_data;
            default: r_line          <= r_line;
         endcase
      end else begin
         r_line <= r_line;
      end
   end

   assign o_req_valid       = w_req_valid;
   assign o_req_addr        = {r_line_addr, 6'd0};
   assign o_req_epoch       = r_epoch;
   assign o_rot_data_in     = r_line;
   assign o_rot_shift       = r_shift;
   assign o_rot_ibuff_valid = r_rvalid;
   assign o_instr_valid     = w_instr_valid;
   assign o_instr           = i_rot_data_out;
   assign o_instr_pc        = {r_line_addr, r_shift};
   assign o_misalign        = r_misalign;

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Bench for fetch_align_ctrl: directed scenarios plus randomized redirects against
// a memory-image reference model; a monitor scoreboards every instruction and request.
module tb_fetch_align_ctrl;

   logic         clk;
   logic         rst_n;
   logic         redir_valid;
   logic [31:0]  redir_pc;
   logic         req_valid;
   logic         req_ready;
   logic [31:0]  req_addr;
   logic         req_epoch;
   logic         fill_valid;
   logic         fill_epoch;
   logic [1:0]   fill_idx;
   logic [127:0] fill_data;
   logic [511:0] rot_data_in;
   logic [5:0]   rot_shift;
   logic [3:0]   rot_ibuff_valid;
   logic [31:0]  rot_data_out;
   logic         rot_valid_out;
   logic         instr_valid;
   logic         instr_ready;
   logic [31:0]  instr;
   logic [31:0]  instr_pc;
   logic         misalign;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   logic [26:0] req_q[$];
   logic        exp_epoch;

   logic        rsp_busy;
   logic [25:0] rsp_line;
   logic        rsp_ep;
   int          rsp_gap;
   logic [1:0]  rsp_order[$];

   logic [31:0] pc;
   int          ncyc;
   logic        found;

   fetch_align_ctrl dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_redir_valid     (redir_valid),
      .i_redir_pc        (redir_pc),
      .o_req_valid       (req_valid),
      .i_req_ready       (req_ready),
      .o_req_addr        (req_addr),
      .o_req_epoch       (req_epoch),
      .i_fill_valid      (fill_valid),
      .i_fill_epoch      (fill_epoch),
      .i_fill_idx        (fill_idx),
      .i_fill_data       (fill_data),
      .o_rot_data_in     (rot_data_in),
      .o_rot_shift       (rot_shift),
      .o_rot_ibuff_valid (rot_ibuff_valid),
      .i_rot_data_out    (rot_data_out),
      .i_rot_valid_out   (rot_valid_out),
      .o_instr_valid     (instr_valid),
      .i_instr_ready     (instr_ready),
      .o_instr           (instr),
      .o_instr_pc        (instr_pc),
      .o_misalign        (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rotator stand-in: 4-byte window starting at byte `shift`, valid when its region is.
   always_comb begin
      rot_data_out  = rot_data_in[10'd511 - {1'b0, rot_shift, 3'b000} -: 32];
      rot_valid_out = rot_ibuff_valid[rot_shift[5:4]];
   end

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [7:0] k;
      k = 8'h22 * {6'b000000, a[1:0]};
      return (8'h01 + k) ^ a[9:2] ^ (a[21:14] * 8'h05);
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
   endfunction

   function automatic logic [127:0] region_data(input logic [25:0] line, input logic [1:0] idx);
      logic [127:0] d;
      logic [31:0]  base;
      base = {line, 6'd0} + {26'd0, idx, 4'd0};
      for (int b = 0; b < 16; b++) d[127 - 8*b -: 8] = mem_byte(base + 32'(b));
      return d;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Redirect for one cycle, then reload the reference stream from the target PC.
   task automatic do_redirect(input logic [31:0] tpc);
      redir_valid = 1'b1;
      redir_pc    = tpc;
      req_ready   = 1'b0;
      fill_valid  = 1'b0;
      step();
      redir_valid = 1'b0;
      exp_q.delete();
      req_q.delete();
      exp_epoch = ~exp_epoch;
      if (tpc[1:0] == 2'b00) begin
         for (int i = 0; i < 200; i++) exp_q.push_back(tpc + 32'(4*i));
         for (int i = 0; i < 12; i++) req_q.push_back({exp_epoch, tpc[31:6] + 26'(i)});
      end
   endtask

   task automatic drive_fill(input logic [25:0] line, input logic [1:0] idx, input logic ep);
      fill_valid = 1'b1;
      fill_idx   = idx;
      fill_epoch = ep;
      fill_data  = region_data(line, idx);
      step();
      fill_valid = 1'b0;
   endtask

   task automatic resp_drive();
      fill_valid = 1'b0;
      if (rsp_busy) begin
         if (rsp_gap > 0) begin
            rsp_gap--;
         end else begin
            fill_idx   = rsp_order.pop_front();
            fill_valid = 1'b1;
            fill_epoch = rsp_ep;
            fill_data  = region_data(rsp_line, fill_idx);
            rsp_gap    = int'($urandom_range(0, 2));
            if (rsp_order.size() == 0) rsp_busy = 1'b0;
         end
      end
      req_ready = !rsp_busy && ($urandom_range(0, 2) != 0);
   endtask

   task automatic resp_observe();
      logic [1:0] t;
      int j;
      if (req_valid && req_ready) begin
         rsp_busy = 1'b1;
         rsp_line = req_addr[31:6];
         rsp_ep   = req_epoch;
         rsp_gap  = int'($urandom_range(0, 3));
         rsp_order.delete();
         for (int i = 0; i < 4; i++) rsp_order.push_back(2'(i));
         for (int i = 3; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = rsp_order[i];
            rsp_order[i] = rsp_order[j];
            rsp_order[j] = t;
         end
      end
   endtask

   // Scoreboard monitor: every accepted instruction and request is popped and compared.
   always @(negedge clk) begin
      logic [31:0] p;
      logic [26:0] r;
      if (rst_n) begin
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL instr_unexpected: got pc %h expected no instruction", instr_pc);
            end else begin
               p = exp_q.pop_front();
               chk("instr_pc", 64'(instr_pc), 64'(p));
               chk("instr_data", 64'(instr), 64'(mem_word(p)));
            end
         end
         if (req_valid && req_ready) begin
            if (req_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL req_unexpected: got addr %h expected no request", req_addr);
            end else begin
               r = req_q.pop_front();
               chk("req_addr", 64'(req_addr), 64'({r[25:0], 6'd0}));
               chk("req_epoch", 64'(req_epoch), 64'(r[26]));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; redir_valid = 1'b0; redir_pc = 32'd0; req_ready = 1'b0;
      fill_valid = 1'b0; fill_epoch = 1'b0; fill_idx = 2'd0; fill_data = 128'd0;
      instr_ready = 1'b0; exp_epoch = 1'b0; rsp_busy = 1'b0; rsp_line = 26'd0;
      rsp_ep = 1'b0; rsp_gap = 0; found = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_instr_valid", 64'(instr_valid), 64'd0);
      chk("rst_misalign", 64'(misalign), 64'd0);
      chk("rst_shift", 64'(rot_shift), 64'd0);
      chk("rst_ibuff", 64'(rot_ibuff_valid), 64'd0);
      chk("rst_line_zero", 64'(rot_data_in == 512'd0), 64'd1);
      chk("rst_instr_pc", 64'(instr_pc), 64'd0);
      step();
      rst_n = 1'b1;
      step();

      // Boot redirect and minimum latency.
      do_redirect(32'h0000_1000);
      req_ready = 1'b1;
      @(negedge clk);
      chk("boot_req_valid", 64'(req_valid), 64'd1);
      chk("boot_req_addr", 64'(req_addr), 64'h1000);
      chk("boot_req_epoch", 64'(req_epoch), 64'd1);
      step();
      req_ready  = 1'b0;
      fill_valid = 1'b1; fill_idx = 2'd0; fill_epoch = exp_epoch;
      fill_data  = region_data(26'h40, 2'd0);
      @(negedge clk);
      chk("boot_no_early_valid", 64'(instr_valid), 64'd0);
      step();
      fill_valid = 1'b0;
      @(negedge clk);
      chk("boot_instr_valid", 64'(instr_valid), 64'd1);
      chk("boot_instr", 64'(instr), 64'h0123_4567);
      chk("boot_instr_pc", 64'(instr_pc), 64'h1000);
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge clk);
         chk("bp_instr", 64'(instr), 64'h0123_4567);
         chk("bp_instr_pc", 64'(instr_pc), 64'h1000);
         chk("bp_shift", 64'(rot_shift), 64'd0);
      end
      instr_ready = 1'b1;
      repeat (8) step();
      instr_ready = 1'b0;

      // Offset start: only the region holding the target is needed.
      do_redirect(32'h0000_2034);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      @(negedge clk);
      chk("ofs_shift", 64'(rot_shift), 64'd52);
      step();
      drive_fill(26'h80, 2'd3, exp_epoch);
      @(negedge clk);
      chk("ofs_valid", 64'(instr_valid), 64'd1);
      chk("ofs_pc", 64'(instr_pc), 64'h2034);

      // Stall on a late region, then line crossing.
      do_redirect(32'h0000_2000);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      drive_fill(26'h80, 2'd0, exp_epoch);
      drive_fill(26'h80, 2'd1, exp_epoch);
      drive_fill(26'h80, 2'd3, exp_epoch);
      instr_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (instr_pc == 32'h2020) found = 1'b1;
      end
      chk("stall_reached", 64'(found), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         chk("stall_valid", 64'(instr_valid), 64'd0);
         chk("stall_shift", 64'(rot_shift), 64'd32);
      end
      step();
      drive_fill(26'h80, 2'd2, exp_epoch);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (instr_valid && instr_ready && instr_pc == 32'h203C) found = 1'b1;
      end
      chk("cross_seen", 64'(found), 64'd1);
      @(negedge clk);
      chk("cross_req_valid", 64'(req_valid), 64'd1);
      chk("cross_instr_valid", 64'(instr_valid), 64'd0);
      chk("cross_req_addr", 64'(req_addr), 64'h2040);
      step();
      instr_ready = 1'b0;

      // Stale-epoch fill is dropped, current-epoch fill is taken.
      do_redirect(32'h0000_1000);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      do_redirect(32'h0000_3000);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      drive_fill(26'hC0, 2'd0, ~exp_epoch);
      @(negedge clk);
      chk("stale_ibuff", 64'(rot_ibuff_valid), 64'd0);
      chk("stale_valid", 64'(instr_valid), 64'd0);
      step();
      drive_fill(26'hC0, 2'd0, exp_epoch);
      @(negedge clk);
      chk("fresh_ibuff", 64'(rot_ibuff_valid), 64'd1);
      chk("fresh_pc", 64'(instr_pc), 64'h3000);
      chk("fresh_instr", 64'(instr), 64'(mem_word(32'h3000)));

      // Misaligned redirect parks in IDLE; an aligned one clears the flag.
      step();
      do_redirect(32'h0000_1002);
      @(negedge clk);
      chk("mis_flag", 64'(misalign), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         chk("mis_req_valid", 64'(req_valid), 64'd0);
         chk("mis_instr_valid", 64'(instr_valid), 64'd0);
      end
      step();
      do_redirect(32'h0000_1000);
      @(negedge clk);
      chk("mis_clear", 64'(misalign), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         chk("req_hold_valid", 64'(req_valid), 64'd1);
         chk("req_hold_addr", 64'(req_addr), 64'h1000);
      end
      step();

      // Randomized redirects with a reordering, delaying refill responder.
      for (int e = 0; e < 40; e++) begin
         pc = 32'($urandom_range(0, 4095)) << 2;
         if ($urandom_range(0, 9) == 0) pc = pc | 32'd2;
         do_redirect(pc);
         ncyc = int'($urandom_range(20, 150));
         for (int c = 0; c < ncyc; c++) begin
            resp_drive();
            instr_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            resp_observe();
            step();
         end
      end
      instr_ready = 1'b0;
      req_ready   = 1'b0;
      fill_valid  = 1'b0;

      // Asynchronous reset while running, then a late fill arriving in IDLE.
      do_redirect(32'h0000_1000);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      drive_fill(26'h40, 2'd0, exp_epoch);
      @(negedge clk);
      chk("pre_rst_valid", 64'(instr_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_req_valid", 64'(req_valid), 64'd0);
      chk("arst_instr_valid", 64'(instr_valid), 64'd0);
      chk("arst_shift", 64'(rot_shift), 64'd0);
      chk("arst_ibuff", 64'(rot_ibuff_valid), 64'd0);
      chk("arst_line_zero", 64'(rot_data_in == 512'd0), 64'd1);
      chk("arst_instr_pc", 64'(instr_pc), 64'd0);
      chk("arst_req_epoch", 64'(req_epoch), 64'd0);
      exp_q.delete();
      req_q.delete();
      exp_epoch = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      drive_fill(26'h40, 2'd0, 1'b0);
      @(negedge clk);
      chk("idle_fill_ibuff", 64'(rot_ibuff_valid), 64'd0);
      chk("idle_fill_line_zero", 64'(rot_data_in == 512'd0), 64'd1);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
